// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The wrap-increment helper is used by both the RTL and its bench model.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Increments idx and wraps to 0 at n, so any n works, not only powers of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority search: finds the first set req bit starting at
// start and wrapping at NUM_REQ.
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic               found,
    output logic [ID_W-1:0]    sel
);

    int unsigned idx;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between NUM_REQ producers: round-robin grants,
// bursts of up to MAX_BURST beats, stalls on fifo_full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    arb_state_t      state, state_n;
    logic [ID_W-1:0] owner, owner_n;
    logic [ID_W-1:0] rr_ptr, rr_ptr_n;
    logic [BW-1:0]   beat_cnt, beat_cnt_n;

    logic                  sel_found;
    logic [ID_W-1:0]       sel_idx;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  accept;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_select (
        .req   (req_valid),
        .start (rr_ptr),
        .found (sel_found),
        .sel   (sel_idx)
    );

    // Compare-based mux keeps the slice index in range for non-power-of-two NUM_REQ.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == ID_W'(i)) begin
                owner_valid = req_valid[i];
                owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept       = (state == ST_BURST) && owner_valid && !fifo_full && !reset;
    assign grant        = accept ? (NUM_REQ'(1) << owner) : '0;
    assign write_enable = accept;
    assign write_data   = accept ? owner_data : '0;
    assign grant_id     = owner;
    assign busy         = (state == ST_BURST);

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    state_n    = ST_BURST;
                    owner_n    = sel_idx;
                    beat_cnt_n = '0;
                end
            end
            ST_BURST: begin
                if (accept) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_n    = ST_IDLE;
                        rr_ptr_n   = ID_W'(wrap_inc(int'(owner), NUM_REQ));
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt + 1'b1;
                    end
                end else if (!owner_valid) begin
                    // A dropped valid ends the burst even while the FIFO is full.
                    state_n    = ST_IDLE;
                    rr_ptr_n   = ID_W'(wrap_inc(int'(owner), NUM_REQ));
                    beat_cnt_n = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a burst-level reference model.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   grant;
    logic           write_enable;
    logic [W-1:0]   write_data;
    logic [IW-1:0]  grant_id;
    logic           busy;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .fifo_full    (fifo_full),
        .grant        (grant),
        .write_enable (write_enable),
        .write_data   (write_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: burst owner, beats taken so far, search pointer.
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_after_rst = 1'b0;
    int unsigned m_owner = 0;
    int unsigned m_taken = 0;
    int unsigned m_ptr = 0;
    int unsigned m_credit [N];

    logic [W-1:0] dat [N];
    bit           inc_data = 1'b1;
    bit           prev_busy = 1'b0;
    int unsigned  owners[$];
    logic [W-1:0] wq[$];
    int unsigned  obs_cnt [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_records();
        owners.delete();
        wq.delete();
        for (int i = 0; i < N; i++) begin
            obs_cnt[i]  = 0;
            m_credit[i] = 0;
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic full, input logic rst);
        logic         ea;
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        @(negedge clk);
        req_valid = v;
        fifo_full = full;
        reset     = rst;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
        #2;
        ea = m_busy && v[m_owner] && !full && !rst;
        eg = ea ? (N'(1) << m_owner) : '0;
        ed = ea ? dat[m_owner] : '0;
        if (m_valid) begin
            check("grant", 32'(grant), 32'(eg));
            check("write_enable", 32'(write_enable), 32'(ea));
            check("write_data", 32'(write_data), 32'(ed));
            check("busy", 32'(busy), 32'(m_busy));
            check("no_write_when_full", 32'(write_enable & fifo_full), 32'(0));
            if (m_busy || m_after_rst) check("grant_id", 32'(grant_id), 32'(m_owner));
        end
        if (busy && !prev_busy) owners.push_back(int'(grant_id));
        prev_busy = busy;
        for (int i = 0; i < N; i++) if (grant[i]) obs_cnt[i]++;
        if (write_enable) wq.push_back(write_data);

        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_taken = 0; m_valid = 1'b1;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int unsigned idx;
                idx = (m_ptr + k) % N;
                if (!m_busy && v[idx]) begin
                    m_busy = 1; m_owner = idx; m_taken = 0;
                end
            end
        end else if (ea) begin
            m_taken++;
            m_credit[m_owner]++;
            if (m_taken == MB) begin
                m_busy = 0;
                m_ptr  = wrap_inc(m_owner, N);
            end
        end else if (!v[m_owner]) begin
            m_busy = 0;
            m_ptr  = wrap_inc(m_owner, N);
        end
        m_after_rst = rst;
        if (ea) dat[m_owner_at(ea, eg)] = inc_data ? dat[m_owner_at(ea, eg)] + 1'b1 : W'($urandom);
    endtask

    function automatic int unsigned m_owner_at(input logic ea, input logic [N-1:0] eg);
        int unsigned r;
        r = 0;
        for (int i = 0; i < N; i++) if (ea && eg[i]) r = i;
        return r;
    endfunction

    task automatic do_reset();
        step('0, 1'b0, 1'b1);
        clear_records();
    endtask

    task automatic check_owners(input string tag, input int unsigned exp[$]);
        check({tag, "_count"}, 32'(owners.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < owners.size(); i++)
            check(tag, 32'(owners[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [N-1:0] rv;
        for (int i = 0; i < N; i++) dat[i] = W'(8'h10 * i);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);

        // Single requester, two full bursts back to back.
        dat[0] = 8'hA0;
        do_reset();
        for (int c = 0; c < 10; c++) step(4'b0001, 1'b0, 1'b0);
        check_owners("t1_owner", '{0, 0});
        check("t1_beats", 32'(obs_cnt[0]), 32'(8));
        check("t1_first_data", 32'(wq[0]), 32'(8'hA0));
        check("t1_last_data", 32'(wq[3]), 32'(8'hA3));

        // All requesters held.
        do_reset();
        for (int c = 0; c < 22; c++) step(4'b1111, 1'b0, 1'b0);
        check_owners("t2_owner", '{0, 1, 2, 3, 0});
        check("t2_beats_r1", 32'(obs_cnt[1]), 32'(4));
        check("t2_beats_r3", 32'(obs_cnt[3]), 32'(4));

        // Backpressure after two beats.
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b0001, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b0001, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b0001, 1'b0, 1'b0);
        check_owners("t3_owner", '{0});
        check("t3_beats", 32'(obs_cnt[0]), 32'(4));

        // Early drop by requester 1.
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b1110, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b1100, 1'b0, 1'b0);
        check_owners("t4_owner", '{1, 2});
        check("t4_beats_r1", 32'(obs_cnt[1]), 32'(2));

        // Sparse requesters with pointer wrap.
        do_reset();
        for (int c = 0; c < 17; c++) step(4'b1010, 1'b0, 1'b0);
        check_owners("t5_owner", '{1, 3, 1, 3});

        // Reset during beat 2 of requester 2.
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0101, 1'b0, 1'b1);
        step(4'b0101, 1'b0, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        check_owners("t6_owner", '{2, 0});
        check("t6_beats_r2", 32'(obs_cnt[2]), 32'(1));

        // Random traffic, data randomised per accepted beat.
        inc_data = 1'b0;
        do_reset();
        rv = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) rv[i] = ~rv[i];
            step(rv, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < N; i++) check("rand_credit", 32'(obs_cnt[i]), 32'(m_credit[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
